// File: rtl/hazwell_alu_pkg.sv
// hazwell_alu_pkg: shared ALU types, opcodes and the slicing legality check.
package hazwell_alu_pkg;

    typedef struct packed {
        logic cout;
        logic ovf;
        logic zero;
    } alu_flags_t;

    localparam logic ALU_OP_ADD = 1'b0;
    localparam logic ALU_OP_SUB = 1'b1;

    // Slice width, or 0 when N cannot be split evenly into STAGES slices.
    function automatic int slice_width(input int n, input int stages);
        return (stages >= 1 && stages <= n && n % stages == 0) ? n / stages : 0;
    endfunction

endpackage

// File: rtl/pipe_addsub_slice.sv
// adder_slice: combinational W-bit generate/propagate ripple slice.
module adder_slice #(
    parameter int W = 4
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_c,
    output logic [W-1:0] o_s,
    output logic         o_co,
    output logic         o_cm
);
    logic [W-1:0] w_g;
    logic [W-1:0] w_p;
    logic [W:0]   w_c;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    always_comb begin
        w_c[0] = i_c;
        for (int i = 0; i < W; i++) w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
    end

    assign o_s  = w_p ^ w_c[W-1:0];
    assign o_co = w_c[W];
    assign o_cm = w_c[W-1];
endmodule

// File: rtl/pipe_addsub.sv
// pipe_addsub: STAGES-deep sliced add/subtract with registered carries and a
// global-stall valid/ready handshake.
module pipe_addsub
    import hazwell_alu_pkg::*;
#(
    parameter int N      = 16,
    parameter int STAGES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] s,
    output logic         cout,
    output logic         ovf,
    output logic         zero
);
    localparam int W = slice_width(N, STAGES);

    if (W == 0) begin : g_bad
        $fatal(1, "pipe_addsub: N must be a multiple of STAGES with 1 <= STAGES <= N");
    end

    logic         w_adv;
    logic [N-1:0] w_be;
    logic         w_ci;

    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;
    assign w_be     = (sub == ALU_OP_ADD) ? b : ~b;
    assign w_ci     = cin ^ (sub == ALU_OP_SUB);

    // Stage k resolves slice k; r_s grows by one slice per stage while the
    // pending operand slices shrink by one.
    for (genvar k = 0; k < STAGES; k++) begin : g_st
        logic [W-1:0]       w_a;
        logic [W-1:0]       w_b;
        logic [W-1:0]       w_sl;
        logic               w_c;
        logic               w_v;
        logic               w_co;
        logic [(k+1)*W-1:0] w_s;
        logic [(k+1)*W-1:0] r_s;
        logic               r_v;

        if (k == 0) begin : g_src
            assign w_a = a[W-1:0];
            assign w_b = w_be[W-1:0];
            assign w_c = w_ci;
            assign w_v = in_valid;
            assign w_s = w_sl;
        end else begin : g_src
            assign w_a = g_st[k-1].g_fwd.r_a[W-1:0];
            assign w_b = g_st[k-1].g_fwd.r_b[W-1:0];
            assign w_c = g_st[k-1].g_fwd.r_c;
            assign w_v = g_st[k-1].r_v;
            assign w_s = {w_sl, g_st[k-1].r_s};
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_v <= 1'b0;
                r_s <= '0;
            end else if (w_adv) begin
                r_v <= w_v;
                r_s <= w_s;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            localparam int R = N - (k + 1) * W;
            logic [R-1:0] r_a;
            logic [R-1:0] r_b;
            logic [R-1:0] w_na;
            logic [R-1:0] w_nb;
            logic         r_c;
            logic         w_cm_unused;

            if (k == 0) begin : g_nx
                assign w_na = a[N-1:W];
                assign w_nb = w_be[N-1:W];
            end else begin : g_nx
                assign w_na = g_st[k-1].g_fwd.r_a[R+W-1:W];
                assign w_nb = g_st[k-1].g_fwd.r_b[R+W-1:W];
            end

            adder_slice #(.W(W)) u_slice (
                .i_a (w_a),
                .i_b (w_b),
                .i_c (w_c),
                .o_s (w_sl),
                .o_co(w_co),
                .o_cm(w_cm_unused)
            );

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_a <= '0;
                    r_b <= '0;
                    r_c <= 1'b0;
                end else if (w_adv) begin
                    r_a <= w_na;
                    r_b <= w_nb;
                    r_c <= w_co;
                end
            end
        end else begin : g_last
            logic       w_cm;
            alu_flags_t r_f;

            adder_slice #(.W(W)) u_slice (
                .i_a (w_a),
                .i_b (w_b),
                .i_c (w_c),
                .o_s (w_sl),
                .o_co(w_co),
                .o_cm(w_cm)
            );

            always_ff @(posedge clk or posedge rst) begin
                if (rst) r_f <= '0;
                else if (w_adv) r_f <= '{cout: w_co, ovf: w_co ^ w_cm, zero: (w_s == '0)};
            end
        end
    end

    assign out_valid = g_st[STAGES-1].r_v;
    assign s         = g_st[STAGES-1].r_s;
    assign cout      = g_st[STAGES-1].g_last.r_f.cout;
    assign ovf       = g_st[STAGES-1].g_last.r_f.ovf;
    assign zero      = g_st[STAGES-1].g_last.r_f.zero;
endmodule

// File: tb/tb_pipe_addsub.sv
// tb_pipe_addsub: scoreboard bench for the 16/4 unit plus a 32-bit STAGES sweep.
module tb_pipe_addsub;
    typedef struct {
        logic [31:0] s;
        logic        cout;
        logic        ovf;
        logic        zero;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        in_valid = 1'b0, in_ready, sub = 1'b0, cin = 1'b0;
    logic        out_valid, out_ready = 1'b1, cout, ovf, zero;
    logic [15:0] a = '0, b = '0, s;

    pipe_addsub #(.N(16), .STAGES(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .cin(cin), .out_valid(out_valid),
        .out_ready(out_ready), .s(s), .cout(cout), .ovf(ovf), .zero(zero)
    );

    // Independent reference: plain integer arithmetic, signed range test for ovf.
    function automatic exp_t model(input int n, input logic [31:0] xa, input logic [31:0] xb,
                                   input logic xs, input logic xc);
        exp_t   e;
        longint lim, ua, ub, sa, sb, c, ur, sr;
        lim = longint'(1) << n;
        ua  = {32'b0, xa};
        ub  = {32'b0, xb};
        c   = xc ? 1 : 0;
        sa  = (ua >= lim / 2) ? ua - lim : ua;
        sb  = (ub >= lim / 2) ? ub - lim : ub;
        ur  = xs ? ua - ub - c : ua + ub + c;
        sr  = xs ? sa - sb - c : sa + sb + c;
        e.s    = 32'(ur & (lim - 1));
        e.cout = xs ? (ua >= ub + c) : (ur >= lim);
        e.ovf  = (sr >= lim / 2) || (sr < -(lim / 2));
        e.zero = (ur & (lim - 1)) == 0;
        e.cyc  = 0;
        return e;
    endfunction

    exp_t q[$];
    exp_t me;

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL main_unexpected: got s=%h with no operation pending, required none", s);
                end else begin
                    me = q.pop_front();
                    if ({s, cout, ovf, zero} !== {me.s[15:0], me.cout, me.ovf, me.zero}) begin
                        errors++;
                        $display("FAIL main_result: got s=%h cout=%b ovf=%b zero=%b, required s=%h cout=%b ovf=%b zero=%b",
                                 s, cout, ovf, zero, me.s[15:0], me.cout, me.ovf, me.zero);
                    end
                end
            end
            if (in_valid && in_ready) q.push_back(model(16, {16'b0, a}, {16'b0, b}, sub, cin));
        end
    end

    logic        sw_valid = 1'b0, sw_sub = 1'b0, sw_cin = 1'b0;
    logic [31:0] sw_a = '0, sw_b = '0;

    for (genvar g = 0; g < 3; g++) begin : g_sw
        localparam int ST = (g == 0) ? 1 : (g == 1) ? 2 : 8;
        logic        rdy, ov, co, of, zr;
        logic [31:0] so;
        exp_t        sq[$];
        exp_t        se;

        pipe_addsub #(.N(32), .STAGES(ST)) u_dut (
            .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(rdy),
            .a(sw_a), .b(sw_b), .sub(sw_sub), .cin(sw_cin), .out_valid(ov),
            .out_ready(1'b1), .s(so), .cout(co), .ovf(of), .zero(zr)
        );

        always @(negedge clk) begin
            if (!rst) begin
                if (ov) begin
                    checks++;
                    if (sq.size() == 0) begin
                        errors++;
                        $display("FAIL sweep%0d_unexpected: got s=%h with no operation pending", ST, so);
                    end else begin
                        se = sq.pop_front();
                        if ({so, co, of, zr} !== {se.s, se.cout, se.ovf, se.zero}) begin
                            errors++;
                            $display("FAIL sweep%0d_result: got s=%h cout=%b ovf=%b zero=%b, required s=%h cout=%b ovf=%b zero=%b",
                                     ST, so, co, of, zr, se.s, se.cout, se.ovf, se.zero);
                        end
                        checks++;
                        if (cyc - se.cyc != ST) begin
                            errors++;
                            $display("FAIL sweep%0d_latency: got %0d cycles, required %0d", ST, cyc - se.cyc, ST);
                        end
                    end
                end
                if (sw_valid && rdy) begin
                    se     = model(32, sw_a, sw_b, sw_sub, sw_cin);
                    se.cyc = cyc;
                    sq.push_back(se);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] xa, input logic [15:0] xb, input logic xs, input logic xc);
        bit acc;
        int n = 0;
        in_valid = 1'b1; a = xa; b = xb; sub = xs; cin = xc;
        do begin
            @(negedge clk);
            acc = in_ready;
            tick();
            n++;
        end while (!acc && n < 50);
        if (!acc) begin
            checks++; errors++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 60) begin
            tick();
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results outstanding, required 0", q.size());
        end
    endtask

    task automatic wait_out(input string name);
        int n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        if (!out_valid) begin
            checks++; errors++;
            $display("FAIL %s_timeout: out_valid=0, required 1", name);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; out_ready = 1'b1;
        repeat (3) tick();
        checks++;
        if ({out_valid, s, cout, ovf, zero} !== 20'b0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b s=%h cout=%b ovf=%b zero=%b, required all 0",
                     out_valid, s, cout, ovf, zero);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
        tick();
    endtask

    task automatic test_basic();
        int lat = 1;
        send(16'h00FF, 16'h0001, 1'b0, 1'b0);
        in_valid = 1'b0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        checks++;
        if (lat != 4) begin
            errors++;
            $display("FAIL basic_latency: got %0d cycles, required 4", lat);
        end
        checks++;
        if ({s, cout, ovf, zero} !== {16'h0100, 3'b000}) begin
            errors++;
            $display("FAIL basic_add: got s=%h cout=%b ovf=%b zero=%b, required s=0100 cout=0 ovf=0 zero=0",
                     s, cout, ovf, zero);
        end
        drain();
    endtask

    task automatic test_sub();
        send(16'h0005, 16'h0005, 1'b1, 1'b0);
        send(16'h0003, 16'h0005, 1'b1, 1'b0);
        in_valid = 1'b0;
        wait_out("sub");
        checks++;
        if ({s, cout, zero} !== {16'h0000, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL sub_zero: got s=%h cout=%b zero=%b, required s=0000 cout=1 zero=1", s, cout, zero);
        end
        tick();
        checks++;
        if ({out_valid, s, cout, zero} !== {1'b1, 16'hFFFE, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL sub_borrow: got valid=%b s=%h cout=%b zero=%b, required valid=1 s=fffe cout=0 zero=0",
                     out_valid, s, cout, zero);
        end
        drain();
    endtask

    task automatic test_carry();
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        send(16'hFFFF, 16'h0001, 1'b0, 1'b1);
        in_valid = 1'b0;
        wait_out("carry");
        checks++;
        if ({s, cout, ovf} !== {16'h8000, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL carry_ovf: got s=%h cout=%b ovf=%b, required s=8000 cout=0 ovf=1", s, cout, ovf);
        end
        tick();
        checks++;
        if ({out_valid, s, cout, ovf} !== {1'b1, 16'h0001, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL carry_out: got valid=%b s=%h cout=%b ovf=%b, required valid=1 s=0001 cout=1 ovf=0",
                     out_valid, s, cout, ovf);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                in_valid = 1'b0;
            end
            begin
                logic [15:0] hold;
                repeat (6) tick();
                out_ready = 1'b0;
                hold = s;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    checks++;
                    if (in_ready !== 1'b0 || out_valid !== 1'b1 || s !== hold) begin
                        errors++;
                        $display("FAIL stall: got in_ready=%b valid=%b s=%h, required in_ready=0 valid=1 s=%h",
                                 in_ready, out_valid, s, hold);
                    end
                    tick();
                end
                out_ready = 1'b1;
            end
        join
        drain();
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) send(16'($urandom), 16'($urandom), 1'b0, 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, s, cout, ovf, zero} !== 20'b0) begin
            errors++;
            $display("FAIL midreset_outputs: got valid=%b s=%h cout=%b ovf=%b zero=%b, required all 0",
                     out_valid, s, cout, ovf, zero);
        end
        q.delete();
        tick();
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_in_ready: got %b, required 1", in_ready);
        end
        tick();
        send(16'd1, 16'd2, 1'b0, 1'b0);
        in_valid = 1'b0;
        wait_out("midreset");
        checks++;
        if (s !== 16'd3) begin
            errors++;
            $display("FAIL midreset_result: got s=%h, required 0003", s);
        end
        drain();
        repeat (8) tick();
    endtask

    task automatic test_sweep();
        int n = 0;
        while (n < 1000) begin
            sw_valid = 1'($urandom_range(0, 4) != 0);
            sw_a     = $urandom;
            sw_b     = $urandom;
            sw_sub   = 1'($urandom_range(0, 1));
            sw_cin   = 1'($urandom_range(0, 1));
            if (n % 97 == 0) sw_b = sw_a;
            n += sw_valid ? 1 : 0;
            tick();
        end
        sw_valid = 1'b0;
        repeat (12) tick();
        checks++;
        if (g_sw[0].sq.size() != 0 || g_sw[1].sq.size() != 0 || g_sw[2].sq.size() != 0) begin
            errors++;
            $display("FAIL sweep_drain: outstanding %0d/%0d/%0d, required 0/0/0",
                     g_sw[0].sq.size(), g_sw[1].sq.size(), g_sw[2].sq.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sub();
        test_carry();
        test_back_to_back();
        test_mid_reset();
        test_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_addsub.md
# pipe_addsub

Parametrised, pipelined add/subtract unit for the ALU. It replaces the single-cycle ripple adder wherever wide operands would otherwise limit clock frequency. Operands are split into `STAGES` equal slices, each resolved in its own pipeline stage with a registered carry. A valid/ready handshake with global stall gives a sustained throughput of one operation per cycle and a latency of `STAGES` cycles.

## Interface
- `N`, 16: operand and result width; must be divisible by `STAGES`.
- `STAGES`, 4: pipeline depth; slice width `W = N/STAGES`. Legal range 1..N.
- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  operation presented on `a`, `b`, `sub`, `cin`.
- `in_ready`  out  1  unit accepts the operation this cycle.
- `a`  in  N  operand A.
- `b`  in  N  operand B.
- `sub`  in  1  0 = add, 1 = subtract.
- `cin`  in  1  carry-in for add, borrow-in for subtract.
- `out_valid`  out  1  result fields are valid.
- `out_ready`  in  1  consumer takes the result this cycle.
- `s`  out  N  result.
- `cout`  out  1  carry-out; for subtract, 1 = no borrow.
- `ovf`  out  1  signed two's-complement overflow.
- `zero`  out  1  `s == 0`.

## Operation
- Arithmetic:
  - effective B is `b ^ {N{sub}}`; effective carry-in is `cin ^ sub`.
  - add: `{cout,s} = a + b + cin`.
  - subtract: `s = a - b - cin` (mod 2^N), with `cout = 1` iff `a >= b + cin` unsigned.
  - `ovf` = carry into bit N-1 XOR carry out of bit N-1.
- Slicing: stage k (0..STAGES-1) adds slice bits `[k*W +: W]` using the carry registered by stage k-1. Stage 0 uses the effective carry-in.
- Operand skew: unprocessed slices of A and effective B, and already-computed sum slices, travel through stage registers alongside the carry. No slice is computed twice.
- Pipeline control:
  - `advance = !out_valid || out_ready`; every stage register, including valid bits, loads only when `advance` = 1.
  - `in_ready = advance`.
  - A transfer occurs when `in_valid && in_ready`. When `advance` = 1 and `in_valid` = 0, a bubble (valid = 0) enters stage 0.
- Flags are produced from the final stage's full result. `zero` and `ovf` are registered with `s`.
- Outputs are held stable while `out_valid && !out_ready`.
- `STAGES = 1` degenerates to a single registered full-width adder with the same handshake.

## Timing
- Latency: an operation accepted at edge t appears with `out_valid` = 1 after edge t+STAGES-1, i.e. `STAGES` cycles, assuming no stall.
- Throughput: one operation per cycle when `out_ready` is held high.
- Stall: `out_valid && !out_ready` freezes the entire pipeline. No bubbles are squeezed out, so `in_ready` = 0 for the same cycle(s).
- Simultaneous output handshake and input acceptance in one cycle is legal and is the steady state.
- Reset, at any time including mid-stream:
  - all stage valids are cleared immediately and in-flight operations are discarded;
  - `out_valid` = 0, `s` = 0, `cout` = 0, `ovf` = 0, `zero` = 0;
  - `in_ready` = 1 as soon as `rst` deasserts, since `out_valid` = 0.
- No combinational path from `a`/`b` to any output. `in_ready` depends combinationally on `out_ready`.

## Structure
- Sub-module `adder_slice` (parameter `W`): combinational W-bit generate/propagate ripple slice. It outputs the sum slice, the carry-out, and the carry into its MSB (for `ovf`). It is instantiated `STAGES` times.
- The shared package `hazwell_alu_pkg` holds:
  - `alu_flags_t` struct `{cout, ovf, zero}`;
  - constants `ALU_OP_ADD = 1'b0` and `ALU_OP_SUB = 1'b1`;
  - the legality check function `slice_width(N, STAGES)`.
- `pipe_addsub` owns the stage registers, valid chain and stall logic. Elaboration fails if `N % STAGES != 0`.

## Test plan
Defaults: N=16, STAGES=4.
- Basic add: after reset, a=0x00FF, b=0x0001, sub=0, cin=0, `out_ready` = 1 → 4 cycles later s=0x0100, cout=0, ovf=0, zero=0.
- Subtract, borrow and zero: a=0x0005, b=0x0005, sub=1 → s=0x0000, cout=1, zero=1. Then a=0x0003, b=0x0005, sub=1 → s=0xFFFE, cout=0.
- Cross-slice carry and overflow: a=0x7FFF, b=0x0001, sub=0 → s=0x8000, ovf=1, cout=0. Then a=0xFFFF, b=0x0001, cin=1 → s=0x0001, cout=1.
- Back-to-back with stall:
  - stream 8 random operations with `out_ready` = 1;
  - hold `out_ready` = 0 for 3 cycles mid-stream → `in_ready` = 0 and `s` stable during the stall;
  - all 8 results arrive in order and match the reference model.
- Reset mid-operation: assert `rst` with 3 operations in flight → `out_valid` drops immediately and outputs are zero. After release, a new op a=1, b=2 returns s=3 with no stale results emitted.
- Parameter sweep: N=32 with STAGES ∈ {1,2,8}, 1000 random ops each → exact match with the reference model; latency equals `STAGES`.
